// File: rtl/stream_demux_pkg.sv
// Shared constants for the stream demultiplexer.
//   DEMUX_DATA_W : default payload width
//   DEMUX_DEPTH  : default entries per output FIFO
//   PORT1_SEL / PORT2_SEL : in_sel encodings for the two destinations
//   count_w()    : width of an occupancy counter able to hold 0..depth
package demux_pkg;

  localparam int   DEMUX_DATA_W = 8;
  localparam int   DEMUX_DEPTH  = 4;
  localparam logic PORT1_SEL    = 1'b0;
  localparam logic PORT2_SEL    = 1'b1;

  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Bundle of the demultiplexer's stream signals.
//   in_*   : one valid/ready input stream with destination tag in_sel
//   out1_* : first-word-fall-through output port 1 plus its occupancy
//   out2_* : same for port 2
// modport master : producer/consumer side (drives in_*, outN_ready)
// modport slave  : demultiplexer side
interface stream_demux_if
  import demux_pkg::*;
#(
  parameter int DATA_W = DEMUX_DATA_W,
  parameter int DEPTH  = DEMUX_DEPTH
);

  localparam int CNT_W = count_w(DEPTH);

  logic [DATA_W-1:0] in_data;
  logic              in_sel;
  logic              in_valid;
  logic              in_ready;

  logic [DATA_W-1:0] out1_data;
  logic              out1_valid;
  logic              out1_ready;
  logic [CNT_W-1:0]  out1_count;

  logic [DATA_W-1:0] out2_data;
  logic              out2_valid;
  logic              out2_ready;
  logic [CNT_W-1:0]  out2_count;

  modport master (
    output in_data, in_sel, in_valid, out1_ready, out2_ready,
    input  in_ready, out1_data, out1_valid, out1_count,
           out2_data, out2_valid, out2_count
  );

  modport slave (
    input  in_data, in_sel, in_valid, out1_ready, out2_ready,
    output in_ready, out1_data, out1_valid, out1_count,
           out2_data, out2_valid, out2_count
  );

endinterface

// File: rtl/stream_demux_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst        : clock, synchronous active-high reset (clears storage too)
//   wr_en, wr_data  : push request; ignored while full
//   full            : no free entry (a same-cycle pop does not make room)
//   rd_en           : pop request; ignored while empty
//   rd_data         : memory[read pointer], the current head
//   empty, count    : occupancy status
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   full,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two; the separate
  // counter distinguishes full from empty when the pointers are equal.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers see pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: the storage array is cleared on reset on purpose, so the head
      // reads back as zero immediately after reset rather than stale data.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-2 stream demultiplexer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : stream_demux_if.slave -- input stream with in_sel tag, two
//              FWFT output ports with independent ready and occupancy.
// Each accepted word is steered into the FIFO picked by in_sel; the
// consumers then drain their FIFOs independently.
module stream_demux
  import demux_pkg::*;
#(
  parameter int DATA_W = DEMUX_DATA_W,
  parameter int DEPTH  = DEMUX_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  stream_demux_if.slave bus
);

  logic full1, full2;
  logic empty1, empty2;
  logic in_ready_w;
  logic accept;
  logic wr1, wr2;

  // Ready looks only at the selected FIFO's registered fullness, never at
  // the consumers' ready, so there is no ready-to-ready combinational path.
  // A word for a full port stalls the whole input: no reordering.
  assign in_ready_w   = (bus.in_sel == PORT2_SEL) ? !full2 : !full1;
  assign bus.in_ready = in_ready_w;
  assign accept       = bus.in_valid && in_ready_w;
  assign wr1          = accept && (bus.in_sel == PORT1_SEL);
  assign wr2          = accept && (bus.in_sel == PORT2_SEL);

  assign bus.out1_valid = !empty1;
  assign bus.out2_valid = !empty2;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr1),
    .wr_data (bus.in_data),
    .full    (full1),
    .rd_en   (bus.out1_ready),
    .rd_data (bus.out1_data),
    .empty   (empty1),
    .count   (bus.out1_count)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo2 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr2),
    .wr_data (bus.in_data),
    .full    (full2),
    .rd_en   (bus.out2_ready),
    .rd_data (bus.out2_data),
    .empty   (empty2),
    .count   (bus.out2_count)
  );

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered 1-to-2 stream demultiplexer: the receiving-side counterpart of the 8-bit 2:1 data selector. One valid/ready input stream carries a byte plus a `in_sel` tag. Each accepted byte goes to output port 1 (`in_sel`=0) or output port 2 (`in_sel`=1), through a per-port first-word-fall-through FIFO. Each consumer can therefore stall independently without losing data.

## Interface
- `DATA_W`, 8, payload width in bits
- `DEPTH`, 4, entries per output FIFO; power of two, ≥2
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  DATA_W  payload
- `in_sel`  in  1  destination: 0 → port 1, 1 → port 2
- `in_valid`  in  1  producer has a word
- `in_ready`  out  1  selected destination FIFO can accept
- `out1_data`  out  DATA_W  head of FIFO 1
- `out1_valid`  out  1  FIFO 1 non-empty
- `out1_ready`  in  1  consumer 1 takes head
- `out2_data`, `out2_valid`, `out2_ready`: same as port 1, for FIFO 2
- `out1_count`, `out2_count`  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Input transfer happens when `in_valid && in_ready` at a rising edge. The word is written to FIFO[`in_sel`]. The other FIFO is untouched.
- `in_ready` = !full(FIFO[`in_sel`]). It is combinational on `in_sel` and registered occupancy only. It never depends on `out*_ready`, so there is no ready-to-ready combinational path.
- Output transfer happens when `outN_valid && outN_ready`. Head is popped and the read pointer advances.
- `outN_valid` = occupancy ≠ 0. `outN_data` = memory[read pointer], and it is stable while `outN_valid && !outN_ready`.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is a separate counter: +1 on write only, −1 on read only, unchanged on both.
- Full FIFO: a write is refused (`in_ready`=0). This holds even if the same-cycle pop would free a slot.
- Empty FIFO: `outN_valid`=0. A pop request is ignored.
- Simultaneous push and pop on a non-empty, non-full FIFO: both take effect and occupancy is unchanged.
- A blocked `in_sel`=1 word with a full FIFO 2 stalls the input, even though FIFO 1 has room. Ordering on the input is strict; there is no reordering.
- `in_data`/`in_sel` may change freely while `in_ready`=0. Only the values at the accepting edge matter.

## Timing
- Reset (any cycle, including mid-stream):
  - pointers, occupancy and all memory entries are cleared to 0;
  - `out1_valid`=`out2_valid`=0, `out1_data`=`out2_data`=0, counts=0;
  - `in_ready`=1 from the first cycle after `rst` deasserts;
  - in-flight words are discarded.
- Latency: a word accepted at edge k appears on `outN_data` with `outN_valid`=1 after edge k, i.e. 1 cycle. There is no bypass while empty.
- Throughput: 1 word/cycle sustained when the consumer keeps `outN_ready`=1.
- Counts update on the same edge as the transfer causing them.

## Structure
- Shared package `demux_pkg`: `DATA_W` default, `PORT1_SEL`=1'b0, `PORT2_SEL`=1'b1 constants.
- Sub-module `sync_fifo` (parameters `DATA_W`, `DEPTH`; ports `clk`, `rst`, `wr_en`, `wr_data`, `full`, `rd_en`, `rd_data`, `empty`, `count`). It is instantiated twice.
- The top level holds only the steering logic: write enables from `in_sel`, and the `in_ready` mux.

## Test plan
- Reset, then single words: AB/sel0, then 08/sel1 with both readys=1.
  - `out1_data`=AB valid 1 cycle after acceptance, `out2_data`=08 likewise.
  - Counts return to 0.
- Fill port 1 with readys low: F2,CC,67,49 (sel0), then B1/sel0.
  - `in_ready`=0 with `out1_count`=4 before B1 is offered; B1 is held.
  - After one pop (F2 out), B1 is accepted the next edge. Output order is F2,CC,67,49,B1.
- Head-of-line stall: fill port 2 (4× sel1), then offer 00/sel0.
  - `in_ready`=1 and 00 reaches `out1` while port 2 stays full.
  - Offering FF/sel1: `in_ready`=0 until `out2_ready` pulses.
- Simultaneous push/pop at occupancy 2 on port 1 for 10 cycles: count stays 2, and data emerges in FIFO order across pointer wrap.
- Assert `rst` for 1 cycle with both FIFOs holding 3 words:
  - next cycle valids=0, data=0, counts=0, `in_ready`=1;
  - a subsequent 3D/sel1 appears alone on `out2`.
- Random valid/ready/sel for 5000 cycles against a scoreboard: per-port order is preserved, with no loss or duplication.
